crf_lval_arb: RTL and testbench
===============================

Name: crf_lval_arb

Overview:
- Shared loop-value update scheduler for the CGRA Constant Register File (CRF).
- Each PE's hardware-loop unit emits active-low update requests: trigger, init, plus a 5-bit CRF index. The block buffers them, arbitrates round-robin among NREQ PEs, and performs one CRF read-modify-write per cycle through the single CRF write port.
- It raises a stall toward the global stall tree while requests are pending, so loop unit triggers are never lost.

Parameters:
- NREQ, 4, number of PE loop units sharing the CRF write port.
- IDX_W, 5, CRF index width; must match the loop unit jmp_index width.
- DW, 32, CRF data width.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-low reset.
- req_trig_n  in  NREQ  per-PE loop-value update request, active low, one-cycle pulse.
- req_init_n  in  NREQ  per-PE init qualifier, active low; meaningful only while req_trig_n[i]=0.
- req_index  in  NREQ*IDX_W  per-PE CRF index; slice i is bits [i*IDX_W +: IDX_W].
- cfg_we  in  1  write the per-index init/step table.
- cfg_idx  in  IDX_W  table index.
- cfg_init  in  DW  initial loop value.
- cfg_step  in  DW  per-iteration increment (two's complement).
- crf_rd_addr  out  IDX_W  CRF read address; combinational read.
- crf_rd_data  in  DW  CRF read data for crf_rd_addr, same cycle.
- crf_wr_en  out  1  CRF write strobe.
- crf_wr_addr  out  IDX_W  CRF write address.
- crf_wr_data  out  DW  CRF write data.
- stall_out  out  1  OR'd into Global_Stall.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset (async, low):
  - All pending entries invalid; rr pointer = 0.
  - Init/step table cleared to 0.
  - crf_wr_en=0, crf_wr_addr=0, crf_wr_data=0, ovf_err=0.
  - stall_out=0, crf_rd_addr=0.
  - Reset mid-operation discards all pending and in-flight updates; no CRF write follows reset deassertion.
- Capture:
  - Per PE, one pending entry {valid, init, idx}.
  - On a rising Clk edge with req_trig_n[i]=0, the entry is loaded with init = ~req_init_n[i] and idx = slice i.
  - req_init_n low while req_trig_n is high is ignored.
- Overflow:
  - A new trigger arrives while entry i is valid and not granted this cycle.
  - The new request overwrites the entry and ovf_err sets; it stays set until reset.
  - If entry i is granted in the same cycle, the new request loads cleanly and ovf_err does not set.
- Arbitration (stage S0):
  - Among valid entries, grant the first at or after the rr pointer, modulo NREQ.
  - Grant clears the entry at the edge and sets the pointer to grant+1, wrapping NREQ-1 to 0.
  - With no valid entries, the pointer holds.
  - crf_rd_addr = granted idx, or 0 when idle.
- Execute (stage S1, registered):
  - init=1: crf_wr_data = table[idx].init.
  - init=0: crf_wr_data = base + table[idx].step, modulo 2^DW, where base = crf_rd_data captured in S0.
  - crf_wr_en is high exactly one cycle per granted request.
  - Latency: trigger sampled at edge t; grant in cycle t..t+1; CRF written at edge t+2. The minimum trigger-to-write is 2 cycles.
- Hazard forwarding:
  - When S1 is writing idx X while S0 reads idx X, base = S1 crf_wr_data, not crf_rd_data.
  - Back-to-back increments to one index must accumulate.
- Config:
  - When cfg_we=1, the table entry updates at the edge.
  - An S0 lookup in the same cycle uses the old value.
  - Config writes are only issued while stall_out=0 and no request is in flight.
- stall_out:
  - Combinational: high when any pending entry is valid, or an S0 grant is outstanding.
  - Low when all entries are empty.
- Throughput: one update per cycle sustained, regardless of the index mix.

Decomposition:
- Shared package cgra_loop_pkg holds:
  - LOOP_INIT_OP = 6'b010110 and LOOP_CNT_OP = 6'b010111.
  - IDX_W.
  - typedef lval_pend_t {valid, init, idx}.
  - typedef lval_cfg_t {init, step}.
- Sub-module rr_arb: parameter N; inputs req[N] and ptr; outputs one-hot gnt and gnt_idx. It is reused by other shared-resource blocks.

Test Plan:
- Single increment: table[3]={init 0, step 4}, CRF[3]=10; PE0 pulses trig_n=0, init_n=1, idx=3 → crf_wr_en at edge t+2 with addr 3, data 14; stall_out high 1 cycle.
- Init: PE1 pulses trig_n=0, init_n=0, idx=7, table[7].init=0x20 → CRF[7]=0x20; CRF[7] is not read.
- Round-robin: all 4 PEs trigger the same cycle on idx 0..3 with pointer=2 → writes ordered idx 2,3,0,1 on consecutive cycles; stall_out high 4 cycles; pointer ends at 2.
- Forwarding: PE0 and PE1 trigger together on idx 5, step 1, CRF[5]=0 → writes 1 then 2.
- Overflow: PE0 triggers idx 1, then again next cycle while PE2 holds the grant → ovf_err=1; only the second request is written.
- Reset mid-run: assert Reset with 3 entries pending → no crf_wr_en after release; stall_out=0; ovf_err=0.

Source files
------------

// File: rtl/cgra_loop_pkg.sv
// Shared loop-unit definitions for the CGRA: loop opcodes, CRF index width
// and the records used by the CRF loop-value update scheduler.
package cgra_loop_pkg;

  localparam logic [5:0] LOOP_INIT_OP = 6'b010110;
  localparam logic [5:0] LOOP_CNT_OP  = 6'b010111;

  localparam int NREQ  = 4;
  localparam int IDX_W = 5;
  localparam int DW    = 32;

  // One buffered loop-value update request per PE.
  typedef struct packed {
    logic             valid;
    logic             init;
    logic [IDX_W-1:0] idx;
  } lval_pend_t;

  // Per-index loop configuration: value loaded on init, increment otherwise.
  typedef struct packed {
    logic [DW-1:0] init;
    logic [DW-1:0] step;
  } lval_cfg_t;

endpackage

// File: rtl/crf_lval_arb_if.sv
// CRF access bus: combinational read port plus the single write port.
// The master side is the loop-value scheduler, the slave side is the CRF.
interface crf_lval_arb_if #(
  parameter int IDX_W = cgra_loop_pkg::IDX_W,
  parameter int DW    = cgra_loop_pkg::DW
);
  logic [IDX_W-1:0] crf_rd_addr;
  logic [DW-1:0]    crf_rd_data;
  logic             crf_wr_en;
  logic [IDX_W-1:0] crf_wr_addr;
  logic [DW-1:0]    crf_wr_data;

  modport master (
    output crf_rd_addr,
    input  crf_rd_data,
    output crf_wr_en,
    output crf_wr_addr,
    output crf_wr_data
  );

  modport slave (
    input  crf_rd_addr,
    output crf_rd_data,
    input  crf_wr_en,
    input  crf_wr_addr,
    input  crf_wr_data
  );
endinterface

// File: rtl/rr_arb.sv
// Generic round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. The caller owns the pointer and its update policy.
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic          found_s;
  logic [PW-1:0] pos_s;
  int            sum_s;

  // Scan the requesters in rotated order starting at ptr; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    pos_s   = '0;
    sum_s   = 0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr) + k;
      if (sum_s >= N) begin
        sum_s = sum_s - N;
      end else begin
        sum_s = sum_s;
      end
      pos_s = PW'(sum_s);
      if (!found_s && req[pos_s]) begin
        found_s      = 1'b1;
        gnt[pos_s]   = 1'b1;
        gnt_idx      = pos_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/crf_lval_arb.sv
// CRF loop-value update scheduler. Buffers one active-low update request per
// PE loop unit, picks one per cycle round-robin (S0: read CRF, look up the
// init/step table), and writes the new value through the single CRF write
// port one cycle later (S1). A write still sitting in S1 is forwarded into
// S0 so back-to-back increments of one index accumulate.
module crf_lval_arb #(
  parameter int NREQ  = cgra_loop_pkg::NREQ,
  parameter int IDX_W = cgra_loop_pkg::IDX_W,
  parameter int DW    = cgra_loop_pkg::DW
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         req_trig_n,
  input  logic [NREQ-1:0]         req_init_n,
  input  logic [NREQ*IDX_W-1:0]   req_index,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [DW-1:0]           cfg_init,
  input  logic [DW-1:0]           cfg_step,
  crf_lval_arb_if.master          crf,
  output logic                    stall_out,
  output logic                    ovf_err
);
  import cgra_loop_pkg::*;

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TAB_N = 1 << IDX_W;

  lval_pend_t       pend_r [NREQ];
  logic [PW-1:0]    ptr_r;
  lval_cfg_t        tab_r [TAB_N];
  logic             wr_en_r;
  logic [IDX_W-1:0] wr_addr_r;
  logic [DW-1:0]    wr_data_r;
  logic             ovf_r;

  logic [NREQ-1:0]  vld_s;
  logic [NREQ-1:0]  gnt_s;
  logic [NREQ-1:0]  ovf_hit_s;
  logic [PW-1:0]    gnt_idx_s;
  logic             gnt_any_s;
  lval_pend_t       sel_s;
  lval_cfg_t        sel_cfg_s;
  logic [DW-1:0]    base_s;
  logic [DW-1:0]    nxt_data_s;

  // Collect the valid bits of the pending entries for the arbiter.
  always_comb begin
    vld_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      vld_s[i] = pend_r[i].valid;
    end
  end

  rr_arb #(.N(NREQ), .PW(PW)) u_rr_arb (
    .req     (vld_s),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign gnt_any_s = |gnt_s;

  // A trigger overwriting a still-waiting (ungranted) entry loses an update.
  always_comb begin
    ovf_hit_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      ovf_hit_s[i] = ~req_trig_n[i] & pend_r[i].valid & ~gnt_s[i];
    end
  end

  // S0: select the granted entry and its table record (pre-update table).
  always_comb begin
    sel_s     = pend_r[gnt_idx_s];
    sel_cfg_s = tab_r[sel_s.idx];
  end

  // S0: CRF read address follows the grant, parked at 0 while idle.
  always_comb begin
    if (gnt_any_s && sel_s.valid) begin
      crf.crf_rd_addr = sel_s.idx;
    end else begin
      crf.crf_rd_addr = '0;
    end
  end

  // S0: new value; the CRF has not yet absorbed S1's write, so forward it.
  always_comb begin
    if (wr_en_r && (wr_addr_r == sel_s.idx)) begin
      base_s = wr_data_r;
    end else begin
      base_s = crf.crf_rd_data;
    end
    if (sel_s.init) begin
      nxt_data_s = sel_cfg_s.init;
    end else begin
      nxt_data_s = base_s + sel_cfg_s.step;
    end
  end

  // Pending entries: capture triggers, retire grants, advance the rr pointer.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREQ; i++) begin
        pend_r[i] <= '0;
      end
      ptr_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_trig_n[i]) begin
          pend_r[i] <= '{valid: 1'b1, init: ~req_init_n[i],
                         idx: req_index[i*IDX_W +: IDX_W]};
        end else if (gnt_s[i]) begin
          pend_r[i].valid <= 1'b0;
        end
      end
      if (gnt_any_s) begin
        ptr_r <= (gnt_idx_s == PW'(NREQ - 1)) ? '0 : gnt_idx_s + PW'(1);
      end
      if (|ovf_hit_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Init/step table, written by configuration while the scheduler is idle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int t = 0; t < TAB_N; t++) begin
        tab_r[t] <= '0;
      end
    end else if (cfg_we) begin
      tab_r[cfg_idx] <= '{init: cfg_init, step: cfg_step};
    end
  end

  // S1: registered CRF write, exactly one cycle per grant.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      wr_en_r <= gnt_any_s;
      if (gnt_any_s) begin
        wr_addr_r <= sel_s.idx;
        wr_data_r <= nxt_data_s;
      end
    end
  end

  assign crf.crf_wr_en   = wr_en_r;
  assign crf.crf_wr_addr = wr_addr_r;
  assign crf.crf_wr_data = wr_data_r;
  assign stall_out       = |vld_s;
  assign ovf_err         = ovf_r;

endmodule

// File: tb/tb_crf_lval_arb.sv
// Bench for crf_lval_arb: a bench-owned CRF memory, a request-level model
// (logical CRF values updated at grant time, FIFO-free round-robin scan) that
// is compared against the DUT every cycle, and literal write-log checks for
// each directed scenario.
module tb_crf_lval_arb;
  localparam int NREQ = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  trig_n = 4'hF;
  logic [3:0]  init_n = 4'hF;
  logic [19:0] index = 20'h0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_idx = 5'd0;
  logic [31:0] cfg_init = 32'h0;
  logic [31:0] cfg_step = 32'h0;
  logic        stall_out;
  logic        ovf_err;
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = 5'd0;
  logic [31:0] bd_data = 32'h0;
  logic [31:0] mem [32];

  crf_lval_arb_if crf_bus ();

  crf_lval_arb dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_trig_n (trig_n),
    .req_init_n (init_n),
    .req_index  (index),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_init   (cfg_init),
    .cfg_step   (cfg_step),
    .crf        (crf_bus),
    .stall_out  (stall_out),
    .ovf_err    (ovf_err)
  );

  always #5 Clk = ~Clk;

  assign crf_bus.crf_rd_data = mem[crf_bus.crf_rd_addr];

  always @(posedge Clk) begin
    if (crf_bus.crf_wr_en) mem[crf_bus.crf_wr_addr] <= crf_bus.crf_wr_data;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  int checks = 0, failures = 0, cyc = 0, stall_cnt = 0, t0 = 0, n1 = 0;
  bit          m_vld [4];
  bit          m_init [4];
  int          m_idx [4];
  int          m_ptr;
  logic [31:0] m_tinit [32];
  logic [31:0] m_tstep [32];
  logic [31:0] m_crf [32];
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_ovf;
  int          log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int k, input int addr, input logic [31:0] data);
    if (k >= log_addr.size()) begin
      chk({name, "_missing"}, log_addr.size(), k + 1);
    end else begin
      chk({name, "_addr"}, log_addr[k], addr);
      chk({name, "_data"}, log_data[k], data);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREQ; i++) m_vld[i] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_tinit[i] = 32'h0;
      m_tstep[i] = 32'h0;
    end
    m_ptr = 0;
    m_wen = 1'b0;
    m_ovf = 1'b0;
  endtask

  function automatic int m_pick();
    int g;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && m_vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    return g;
  endfunction

  task automatic model_edge();
    int g;
    int id;
    logic [31:0] v;
    g = m_pick();
    m_wen = 1'b0;
    if (g >= 0) begin
      id = m_idx[g];
      v = m_init[g] ? m_tinit[id] : m_crf[id] + m_tstep[id];
      m_crf[id] = v;
      m_wen = 1'b1;
      m_waddr = id;
      m_wdata = v;
      m_vld[g] = 1'b0;
      m_ptr = (g + 1) % NREQ;
    end
    if (cfg_we) begin
      m_tinit[cfg_idx] = cfg_init;
      m_tstep[cfg_idx] = cfg_step;
    end
    if (bd_we) m_crf[bd_addr] = bd_data;
    for (int i = 0; i < NREQ; i++) begin
      if (!trig_n[i]) begin
        if (m_vld[i]) m_ovf = 1'b1;
        m_vld[i] = 1'b1;
        m_init[i] = !init_n[i];
        m_idx[i] = int'(index[i*5 +: 5]);
      end
    end
  endtask

  task automatic compare();
    int g;
    bit any;
    g = m_pick();
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) any = any | m_vld[i];
    chk("wr_en", crf_bus.crf_wr_en, m_wen);
    if (m_wen) begin
      chk("wr_addr", crf_bus.crf_wr_addr, m_waddr);
      chk("wr_data", crf_bus.crf_wr_data, m_wdata);
    end
    chk("stall_out", stall_out, any);
    if (g >= 0) chk("rd_addr", crf_bus.crf_rd_addr, m_idx[g]);
    else chk("rd_addr_idle", crf_bus.crf_rd_addr, 0);
    chk("ovf_err", ovf_err, m_ovf);
    if (crf_bus.crf_wr_en) begin
      log_addr.push_back(int'(crf_bus.crf_wr_addr));
      log_data.push_back(crf_bus.crf_wr_data);
      log_cyc.push_back(cyc);
    end
    if (stall_out) stall_cnt++;
  endtask

  task automatic tick();
    @(posedge Clk);
    cyc++;
    if (Reset) model_edge();
    @(negedge Clk);
    compare();
    trig_n = 4'hF;
    init_n = 4'hF;
    cfg_we = 1'b0;
    bd_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic trig(input int pe, input bit ini, input int idx);
    trig_n[pe] = 1'b0;
    init_n[pe] = !ini;
    index[pe*5 +: 5] = 5'(idx);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    stall_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_crf[i] = 32'h0;
    m_reset();
    idle(2);
    chk("rst_wr_en", crf_bus.crf_wr_en, 0);
    chk("rst_wr_addr", crf_bus.crf_wr_addr, 0);
    chk("rst_wr_data", crf_bus.crf_wr_data, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_rd_addr", crf_bus.crf_rd_addr, 0);
    Reset = 1'b1;

    // CRF contents and loop table
    for (int i = 0; i < 16; i++) begin
      bd_we = 1'b1;
      bd_addr = 5'(i);
      bd_data = (i == 3) ? 32'd10 : (i == 5) ? 32'd0 : 32'h100 + 32'(i);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1'b1;
      cfg_idx = 5'(i);
      cfg_init = (i == 3 || i == 5) ? 32'h0 : (i == 7) ? 32'h20 : 32'h200 + 32'(i);
      cfg_step = (i == 3) ? 32'd4 : (i == 5) ? 32'd1 : 32'(i + 1);
      tick();
    end

    // single increment: CRF[3]=10, step 4
    clear_log();
    trig(0, 1'b0, 3);
    tick();
    t0 = cyc;
    idle(4);
    chk("inc_nwr", log_addr.size(), 1);
    chk_log("inc", 0, 3, 32'd14);
    if (log_cyc.size() > 0) chk("inc_latency", log_cyc[0] - t0, 1);
    chk("inc_stall_cycles", stall_cnt, 1);

    // init load of idx 7
    clear_log();
    trig(1, 1'b1, 7);
    tick();
    idle(4);
    chk("init_nwr", log_addr.size(), 1);
    chk_log("init", 0, 7, 32'h20);

    // round robin, pointer at 2
    clear_log();
    for (int i = 0; i < 4; i++) trig(i, 1'b0, i);
    tick();
    idle(6);
    chk("rr_nwr", log_addr.size(), 4);
    chk_log("rr0", 0, 2, 32'h105);
    chk_log("rr1", 1, 3, 32'd18);
    chk_log("rr2", 2, 0, 32'h101);
    chk_log("rr3", 3, 1, 32'h103);
    chk("rr_stall_cycles", stall_cnt, 4);
    if (log_cyc.size() == 4) chk("rr_back_to_back", log_cyc[3] - log_cyc[0], 3);

    // pointer ended at 2: PE2 wins over PE1
    clear_log();
    trig(1, 1'b0, 8);
    trig(2, 1'b0, 9);
    tick();
    idle(4);
    chk_log("ptr0", 0, 9, 32'h113);
    chk_log("ptr1", 1, 8, 32'h111);

    // forwarding: two increments of idx 5 back to back
    clear_log();
    trig(0, 1'b0, 5);
    trig(1, 1'b0, 5);
    tick();
    idle(4);
    chk_log("fwd0", 0, 5, 32'd1);
    chk_log("fwd1", 1, 5, 32'd2);

    // retrigger while granted: clean load, no overflow
    clear_log();
    trig(1, 1'b0, 10);
    tick();
    trig(1, 1'b0, 10);
    tick();
    idle(4);
    chk_log("regrant0", 0, 10, 32'h115);
    chk_log("regrant1", 1, 10, 32'h120);
    chk("regrant_no_ovf", ovf_err, 0);

    // overflow: PE0 retriggers while PE2 holds the grant
    clear_log();
    trig(0, 1'b1, 1);
    trig(2, 1'b0, 9);
    tick();
    trig(0, 1'b0, 1);
    tick();
    idle(4);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_nwr", log_addr.size(), 2);
    chk_log("ovf0", 0, 9, 32'h11D);
    chk_log("ovf1", 1, 1, 32'h105);
    n1 = 0;
    foreach (log_addr[k]) if (log_addr[k] == 1) n1++;
    chk("ovf_idx1_writes", n1, 1);

    // init_n low without trigger is ignored
    clear_log();
    init_n[3] = 1'b0;
    tick();
    trig(3, 1'b0, 11);
    tick();
    idle(4);
    chk("noinit_nwr", log_addr.size(), 1);
    chk_log("noinit", 0, 11, 32'h117);

    // reset with three entries pending
    trig(0, 1'b0, 12);
    trig(1, 1'b0, 13);
    trig(2, 1'b0, 14);
    tick();
    chk("pre_rst_stall", stall_out, 1);
    Reset = 1'b0;
    #1;
    chk("midrst_stall", stall_out, 0);
    chk("midrst_wr_en", crf_bus.crf_wr_en, 0);
    chk("midrst_ovf", ovf_err, 0);
    m_reset();
    clear_log();
    idle(2);
    Reset = 1'b1;
    idle(5);
    chk("postrst_nwr", log_addr.size(), 0);
    chk("postrst_stall", stall_out, 0);
    chk("postrst_ovf", ovf_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
